// File: rtl/mt_mdf.sv
// Maintenance data field generator: loopback FIFO, pattern generator and write sink paced by the MR BPI clock.
// Optional write parity checking is built when MTMDF_PARITY_EN is defined.
module mt_mdf #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mtMM,
  input  logic [3:0] mtMOP,
  input  logic       mtBPICLK,
  input  logic [8:0] mtWDATA,
  input  logic       mtWSTB,
  output logic       mtWRDY,
  output logic [8:0] mtRDATA,
  output logic       mtRSTB,
  output logic       mtUNF,
  output logic       mtPERR,
  output logic [8:0] mtMDF
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_LOOP, S_PAT, S_WONLY} state_e;

  state_e          state_q, state_d;
  logic            bpi_last_q;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic [8:0]      pat_q;
  logic [8:0]      rdata_q, mdf_q;
  logic            rstb_q, unf_q;
  logic [8:0]      mem [DEPTH];

  logic change, full, empty, accept, bpi_edge;
  logic push, pop, underrun, pat_fire;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_d = S_IDLE;
    if (mtMM) begin
      case (mtMOP)
        4'd1:    state_d = S_LOOP;
        4'd2:    state_d = S_PAT;
        4'd3:    state_d = S_WONLY;
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign change = (state_d != state_q);
  assign full   = (count_q == CW'(DEPTH));
  assign empty  = (count_q == '0);

  // Ready depends only on registered state, so a same-cycle pop never opens a full FIFO.
  always_comb begin
    mtWRDY = 1'b0;
    case (state_q)
      S_LOOP:  mtWRDY = !full;
      S_WONLY: mtWRDY = 1'b1;
      default: mtWRDY = 1'b0;
    endcase
  end

  assign accept   = mtWSTB && mtWRDY;
  assign bpi_edge = mtBPICLK && !bpi_last_q;
  assign push     = accept && (state_q == S_LOOP);
  assign pop      = bpi_edge && (state_q == S_LOOP) && !empty;
  assign underrun = bpi_edge && (state_q == S_LOOP) && empty;
  assign pat_fire = bpi_edge && (state_q == S_PAT);

  // NOTE: the character storage has no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= mtWDATA;
  end

  // NOTE: sequential state is assigned with non-blocking <= so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      bpi_last_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      pat_q      <= '0;
      rdata_q    <= '0;
      mdf_q      <= '0;
      rstb_q     <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bpi_last_q <= mtBPICLK;
      rstb_q     <= pop || pat_fire;
      if (pop)           rdata_q <= mem[rd_ptr_q];
      else if (pat_fire) rdata_q <= pat_q;
      if (accept)        mdf_q   <= mtWDATA;
      else if (pat_fire) mdf_q   <= pat_q;
      // A mode change flushes the FIFO and restarts the flags and pattern.
      if (change) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
        pat_q    <= '0;
        unf_q    <= 1'b0;
      end else begin
        if (push)     wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)      rd_ptr_q <= rd_ptr_q + 1'b1;
        if (push && !pop)      count_q <= count_q + 1'b1;
        else if (pop && !push) count_q <= count_q - 1'b1;
        if (pat_fire) pat_q <= pat_q + 1'b1;
        if (underrun) unf_q <= 1'b1;
      end
    end
  end

`ifdef MTMDF_PARITY_EN
  logic perr_q;
  // Characters must carry odd parity over all nine bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                         perr_q <= 1'b0;
    else if (change)                  perr_q <= 1'b0;
    else if (accept && !(^mtWDATA))   perr_q <= 1'b1;
  end
  assign mtPERR = perr_q;
`else
  assign mtPERR = 1'b0;
`endif

  assign mtRDATA = rdata_q;
  assign mtRSTB  = rstb_q;
  assign mtUNF   = unf_q;
  assign mtMDF   = mdf_q;

endmodule

// File: tb/tb_mt_mdf.sv
// Directed self-checking bench for mt_mdf: reset, loopback, underrun, pattern wrap, flush and parity.
module tb_mt_mdf;

  logic       clk = 1'b0;
  logic       rst;
  logic       mtMM;
  logic [3:0] mtMOP;
  logic       mtBPICLK;
  logic [8:0] mtWDATA;
  logic       mtWSTB;
  logic       mtWRDY;
  logic [8:0] mtRDATA;
  logic       mtRSTB;
  logic       mtUNF;
  logic       mtPERR;
  logic [8:0] mtMDF;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef MTMDF_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  mt_mdf #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .mtMM(mtMM), .mtMOP(mtMOP), .mtBPICLK(mtBPICLK),
    .mtWDATA(mtWDATA), .mtWSTB(mtWSTB), .mtWRDY(mtWRDY), .mtRDATA(mtRDATA),
    .mtRSTB(mtRSTB), .mtUNF(mtUNF), .mtPERR(mtPERR), .mtMDF(mtMDF)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive a new MR mode at a falling edge; it is active one rising edge later.
  task automatic set_mode(input logic mm, input logic [3:0] mop);
    mtMM  = mm;
    mtMOP = mop;
    @(negedge clk);
  endtask

  task automatic write_char(input logic [8:0] d);
    int n;
    n = 0;
    mtWDATA = d;
    mtWSTB  = 1'b1;
    while (!mtWRDY && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("write_timeout", 32'd1, 32'd0);
    @(negedge clk);
    mtWSTB = 1'b0;
  endtask

  // One BPI clock pulse: strobe sampled the cycle after the rise, then checked gone a cycle later.
  task automatic bpi_pulse(output logic stb, output logic [8:0] data);
    mtBPICLK = 1'b1;
    @(negedge clk);
    stb  = mtRSTB;
    data = mtRDATA;
    mtBPICLK = 1'b0;
    @(negedge clk);
    check("rstb_one_cycle", {31'd0, mtRSTB}, 32'd0);
  endtask

  task automatic expect_pop(input string tag, input logic [8:0] exp);
    logic       stb;
    logic [8:0] data;
    bpi_pulse(stb, data);
    check({tag, "_stb"}, {31'd0, stb}, 32'd1);
    check({tag, "_data"}, {23'd0, data}, {23'd0, exp});
  endtask

  initial begin
    logic       stb;
    logic [8:0] data;
    logic [8:0] vec [4];
    vec[0] = 9'h155; vec[1] = 9'h0AA; vec[2] = 9'h1FF; vec[3] = 9'h001;

    rst = 1'b0; mtMM = 1'b0; mtMOP = 4'd0; mtBPICLK = 1'b0;
    mtWDATA = 9'd0; mtWSTB = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_wrdy",  {31'd0, mtWRDY}, 32'd0);
    check("rst_rdata", {23'd0, mtRDATA}, 32'd0);
    check("rst_rstb",  {31'd0, mtRSTB}, 32'd0);
    check("rst_unf",   {31'd0, mtUNF}, 32'd0);
    check("rst_perr",  {31'd0, mtPERR}, 32'd0);
    check("rst_mdf",   {23'd0, mtMDF}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("idle_wrdy", {31'd0, mtWRDY}, 32'd0);

    // Loopback fill to full, refused write, then drain in order.
    set_mode(1'b1, 4'd1);
    check("loop_wrdy", {31'd0, mtWRDY}, 32'd1);
    for (int i = 0; i < 4; i++) write_char(vec[i]);
    check("loop_full_wrdy", {31'd0, mtWRDY}, 32'd0);
    check("loop_mdf", {23'd0, mtMDF}, 32'h001);
    check("loop_perr", {31'd0, mtPERR}, {31'd0, PAR});
    mtWDATA = 9'h0EE; mtWSTB = 1'b1;
    repeat (2) @(negedge clk);
    mtWSTB = 1'b0;
    check("full_refused_mdf", {23'd0, mtMDF}, 32'h001);
    for (int i = 0; i < 4; i++) expect_pop("loop_pop", vec[i]);
    check("drained_wrdy", {31'd0, mtWRDY}, 32'd1);
    check("drained_unf", {31'd0, mtUNF}, 32'd0);

    // Underrun on an empty FIFO, cleared by switching to WONLY.
    bpi_pulse(stb, data);
    check("unf_no_stb", {31'd0, stb}, 32'd0);
    check("unf_set", {31'd0, mtUNF}, 32'd1);
    set_mode(1'b1, 4'd3);
    check("unf_cleared", {31'd0, mtUNF}, 32'd0);
    check("wonly_wrdy", {31'd0, mtWRDY}, 32'd1);
    check("wonly_perr_clear", {31'd0, mtPERR}, 32'd0);

    // Parity in WONLY: 0x003 has even parity, 0x007 odd.
    write_char(9'h003);
    check("par_003", {31'd0, mtPERR}, {31'd0, PAR});
    check("wonly_mdf_003", {23'd0, mtMDF}, 32'h003);
    bpi_pulse(stb, data);
    check("wonly_no_stb", {31'd0, stb}, 32'd0);
    set_mode(1'b0, 4'd0);
    set_mode(1'b1, 4'd3);
    check("par_flushed", {31'd0, mtPERR}, 32'd0);
    write_char(9'h007);
    check("par_007", {31'd0, mtPERR}, 32'd0);
    check("wonly_mdf_007", {23'd0, mtMDF}, 32'h007);

    // Push and BPI edge together on an empty FIFO: underrun, yet the character is kept.
    set_mode(1'b1, 4'd1);
    mtWDATA = 9'h123; mtWSTB = 1'b1; mtBPICLK = 1'b1;
    @(negedge clk);
    mtWSTB = 1'b0; mtBPICLK = 1'b0;
    check("sim_no_stb", {31'd0, mtRSTB}, 32'd0);
    check("sim_unf", {31'd0, mtUNF}, 32'd1);
    @(negedge clk);
    expect_pop("sim_pop", 9'h123);

    // Pop while full does not admit a waiting write in the same cycle.
    set_mode(1'b0, 4'd0);
    set_mode(1'b1, 4'd1);
    for (int i = 0; i < 4; i++) write_char(9'h010 + 9'(i));
    mtWDATA = 9'h0E5; mtWSTB = 1'b1; mtBPICLK = 1'b1;
    @(negedge clk);
    mtBPICLK = 1'b0;
    check("fullpop_stb", {31'd0, mtRSTB}, 32'd1);
    check("fullpop_data", {23'd0, mtRDATA}, 32'h010);
    check("fullpop_mdf", {23'd0, mtMDF}, 32'h013);
    check("fullpop_wrdy", {31'd0, mtWRDY}, 32'd1);
    @(negedge clk);
    mtWSTB = 1'b0;
    check("late_push_mdf", {23'd0, mtMDF}, 32'h0E5);
    for (int i = 1; i < 4; i++) expect_pop("fullpop_rest", 9'h010 + 9'(i));
    expect_pop("fullpop_last", 9'h0E5);

    // Mode flush: two queued, bounce through IDLE, writes refused while idle.
    write_char(9'h0A1);
    write_char(9'h0A2);
    set_mode(1'b1, 4'd7);
    check("flush_idle_wrdy", {31'd0, mtWRDY}, 32'd0);
    mtWDATA = 9'h0B0; mtWSTB = 1'b1;
    @(negedge clk);
    mtWSTB = 1'b0;
    check("flush_idle_mdf", {23'd0, mtMDF}, 32'h0A2);
    set_mode(1'b1, 4'd1);
    bpi_pulse(stb, data);
    check("flush_no_stb", {31'd0, stb}, 32'd0);
    check("flush_unf", {31'd0, mtUNF}, 32'd1);

    // Pattern generator through the 9-bit wrap.
    set_mode(1'b1, 4'd2);
    check("pat_wrdy", {31'd0, mtWRDY}, 32'd0);
    for (int i = 0; i < 513; i++) begin
      bpi_pulse(stb, data);
      check("pat_stb", {31'd0, stb}, 32'd1);
      check("pat_data", {23'd0, data}, i & 32'h1FF);
      check("pat_mdf", {23'd0, mtMDF}, i & 32'h1FF);
    end

    // Reset mid-LOOP with three characters queued.
    set_mode(1'b1, 4'd1);
    for (int i = 0; i < 3; i++) write_char(9'h0C0 + 9'(i));
    rst = 1'b0;
    #1;
    check("mrst_wrdy",  {31'd0, mtWRDY}, 32'd0);
    check("mrst_rdata", {23'd0, mtRDATA}, 32'd0);
    check("mrst_rstb",  {31'd0, mtRSTB}, 32'd0);
    check("mrst_unf",   {31'd0, mtUNF}, 32'd0);
    check("mrst_perr",  {31'd0, mtPERR}, 32'd0);
    check("mrst_mdf",   {23'd0, mtMDF}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      bpi_pulse(stb, data);
      check("mrst_no_stb", {31'd0, stb}, 32'd0);
    end
    check("mrst_rdata_hold", {23'd0, mtRDATA}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
